// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD write arbiter: FSM states, ST7789 window opcodes,
// panel geometry and the window command byte generator.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_CMD,
    ST_FETCH,
    ST_PHI,
    ST_PLO
  } lcd_state_t;

  localparam logic [7:0]  OP_CASET = 8'h2A;
  localparam logic [7:0]  OP_RASET = 8'h2B;
  localparam logic [7:0]  OP_RAMWR = 8'h2C;

  localparam logic [15:0] H_RES = 16'd160;
  localparam logic [15:0] V_RES = 16'd240;

  localparam logic        DC_CMD  = 1'b0;
  localparam logic        DC_DATA = 1'b1;

  localparam logic [3:0]  CMD_LAST = 4'd10;

  // Window programming sequence: CASET x0 x1, RASET y0 y1, RAMWR (coords big-endian)
  function automatic logic [8:0] cmd_byte(input logic [3:0]  idx,
                                          input logic [15:0] x0,
                                          input logic [15:0] x1,
                                          input logic [15:0] y0,
                                          input logic [15:0] y1);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {DC_CMD,  OP_CASET};
      4'd1:    b = {DC_DATA, x0[15:8]};
      4'd2:    b = {DC_DATA, x0[7:0]};
      4'd3:    b = {DC_DATA, x1[15:8]};
      4'd4:    b = {DC_DATA, x1[7:0]};
      4'd5:    b = {DC_CMD,  OP_RASET};
      4'd6:    b = {DC_DATA, y0[15:8]};
      4'd7:    b = {DC_DATA, y0[7:0]};
      4'd8:    b = {DC_DATA, y1[15:8]};
      4'd9:    b = {DC_DATA, y1[7:0]};
      default: b = {DC_CMD,  OP_RAMWR};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_arb2.sv
// lcd_rr_arb2: two-way round-robin pick. prio is the client that wins a tie;
// it flips to the other client after every grant.
module lcd_rr_arb2 (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prio <= 1'b0;
    end else if (grant[0]) begin
      prio <= 1'b1;
    end else if (grant[1]) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the 9-bit LCD byte writer between the init sequencer and two draw clients.
// Optional pixel-stall watchdog enabled with LCD_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_INIT  | init sequencer passes straight through to the writer
// ST_ARB   | idle, round-robin grant and window check
// ST_CMD   | 11 window bytes (CASET/RASET/RAMWR) from idx_q
// ST_FETCH | waiting for a pixel from the granted client
// ST_PHI   | pixel high byte pending
// ST_PLO   | pixel low byte pending
module lcd_write_arbiter
`ifdef LCD_ARB_TIMEOUT_EN
  #(parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000)
`endif
  (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst_n,
  input  logic [8:0]  init_data,
  input  logic        init_en_write,
  input  logic        init_done,
  output logic        init_wr_done,
  input  logic [1:0]  req,
  input  logic [15:0] win_x0,
  input  logic [15:0] win_x1,
  input  logic [15:0] win_y0,
  input  logic [15:0] win_y1,
  output logic [1:0]  grant,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [1:0]  draw_done,
  output logic [1:0]  draw_err,
  output logic [8:0]  lcd_data,
  output logic        lcd_en_write,
  input  logic        wr_done
);
  import lcd_pkg::*;

  lcd_state_t  state_q, state_d;
  logic [3:0]  idx_q;
  logic [15:0] cnt_q;
  logic [15:0] px_q;
  logic [15:0] x0_q, x1_q, y0_q, y1_q;
  logic        cur_q;
  logic [1:0]  done_q, err_q;
  logic        win_ok;
  logic [15:0] pix_total;

  lcd_rr_arb2 u_rr (
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst_n     (sys_rst_n),
    .req           (req),
    .en            (state_q == ST_ARB),
    .grant         (grant)
  );

  assign win_ok    = (win_x1 >= win_x0) && (win_y1 >= win_y0) &&
                     (win_x1 < H_RES) && (win_y1 < V_RES);
  assign pix_total = (win_x1 - win_x0 + 16'd1) * (win_y1 - win_y0 + 16'd1);
  assign draw_done = done_q;
  assign draw_err  = err_q;

`ifdef LCD_ARB_TIMEOUT_EN
  logic [23:0] stall_q;
  logic        stall_hit;

  assign stall_hit = (stall_q == 24'd0);

  // Reloaded outside FETCH and on every capture, so it only times a single stall
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= 24'd0;
    end else if (state_q != ST_FETCH || pix_valid) begin
      stall_q <= TIMEOUT_CYC - 24'd1;
    end else if (!stall_hit) begin
      stall_q <= stall_q - 24'd1;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    lcd_data     = 9'd0;
    lcd_en_write = 1'b0;
    init_wr_done = 1'b0;
    pix_ready    = 1'b0;
    case (state_q)
      ST_INIT: begin
        lcd_data     = init_data;
        lcd_en_write = init_en_write;
        init_wr_done = wr_done;
        if (init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if ((grant != 2'b00) && win_ok) state_d = ST_CMD;
      end
      ST_CMD: begin
        lcd_data     = cmd_byte(idx_q, x0_q, x1_q, y0_q, y1_q);
        lcd_en_write = 1'b1;
        if (wr_done && idx_q == CMD_LAST) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_d = ST_PHI;
`ifdef LCD_ARB_TIMEOUT_EN
        else if (stall_hit) state_d = ST_ARB;
`endif
      end
      ST_PHI: begin
        lcd_data     = {DC_DATA, px_q[15:8]};
        lcd_en_write = 1'b1;
        if (wr_done) state_d = ST_PLO;
      end
      ST_PLO: begin
        lcd_data     = {DC_DATA, px_q[7:0]};
        lcd_en_write = 1'b1;
        if (wr_done) state_d = (cnt_q == 16'd1) ? ST_ARB : ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= 4'd0;
      cnt_q   <= 16'd0;
      px_q    <= 16'd0;
      x0_q    <= 16'd0;
      x1_q    <= 16'd0;
      y0_q    <= 16'd0;
      y1_q    <= 16'd0;
      cur_q   <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      case (state_q)
        ST_ARB: begin
          if (grant != 2'b00) begin
            x0_q  <= win_x0;
            x1_q  <= win_x1;
            y0_q  <= win_y0;
            y1_q  <= win_y1;
            cur_q <= grant[1];
            cnt_q <= pix_total;
            idx_q <= 4'd0;
            if (!win_ok) err_q <= grant;
          end
        end
        ST_CMD: begin
          if (wr_done) idx_q <= idx_q + 4'd1;
        end
        ST_FETCH: begin
          if (pix_valid) px_q <= pix_data;
`ifdef LCD_ARB_TIMEOUT_EN
          else if (stall_hit) err_q <= {cur_q, ~cur_q};
`endif
        end
        ST_PLO: begin
          if (wr_done) begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) done_q <= {cur_q, ~cur_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: a vector table of windows plus hand-written
// init, round-robin, stall, timeout and reset sequences against an LCD writer model.
module tb_lcd_write_arbiter;

  logic        sys_clk_50MHz = 1'b0;
  logic        sys_rst_n;
  logic [8:0]  init_data;
  logic        init_en_write;
  logic        init_done;
  logic        init_wr_done;
  logic [1:0]  req;
  logic [15:0] win_x0, win_x1, win_y0, win_y1;
  logic [1:0]  grant;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [1:0]  draw_done;
  logic [1:0]  draw_err;
  logic [8:0]  lcd_data;
  logic        lcd_en_write;
  logic        wr_done;

  always #10 sys_clk_50MHz = ~sys_clk_50MHz;

`ifdef LCD_ARB_TIMEOUT_EN
  lcd_write_arbiter #(.TIMEOUT_CYC(24'd16)) dut (
`else
  lcd_write_arbiter dut (
`endif
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst_n     (sys_rst_n),
    .init_data     (init_data),
    .init_en_write (init_en_write),
    .init_done     (init_done),
    .init_wr_done  (init_wr_done),
    .req           (req),
    .win_x0        (win_x0),
    .win_x1        (win_x1),
    .win_y0        (win_y0),
    .win_y1        (win_y1),
    .grant         (grant),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .draw_done     (draw_done),
    .draw_err      (draw_err),
    .lcd_data      (lcd_data),
    .lcd_en_write  (lcd_en_write),
    .wr_done       (wr_done)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // writer / pixel source / monitor state
  bit          auto_wr = 1'b0;
  logic        wr_man = 1'b0;
  logic        wr_auto = 1'b0;
  int          wr_wait = 0;
  bit          px_hold = 1'b0;
  bit          px_take = 1'b0;
  logic        pix_valid_r = 1'b0;
  logic [15:0] pix_data_r = 16'd0;
  logic [15:0] pix_src[$];
  logic [8:0]  byte_log[$];
  logic [8:0]  exp_q[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  done_log[$];
  logic [1:0]  err_log[$];
  int          en_cnt = 0;

  assign wr_done   = auto_wr ? wr_auto : wr_man;
  assign pix_valid = pix_valid_r;
  assign pix_data  = pix_data_r;

  initial begin
    forever begin
      @(negedge sys_clk_50MHz);
      if (grant != 2'b00) grant_log.push_back(grant);
      if (draw_done != 2'b00) done_log.push_back(draw_done);
      if (draw_err != 2'b00) err_log.push_back(draw_err);
      if (lcd_en_write) en_cnt++;
      // writer: three cycles per byte, one-cycle wr_done pulse
      if (auto_wr && lcd_en_write && !wr_auto) begin
        if (wr_wait == 2) begin
          wr_auto = 1'b1;
          byte_log.push_back(lcd_data);
          wr_wait = 0;
        end else begin
          wr_wait++;
        end
      end else begin
        wr_auto = 1'b0;
        if (!lcd_en_write) wr_wait = 0;
      end
      // pixel source
      if (px_take && pix_src.size() > 0) void'(pix_src.pop_front());
      pix_valid_r = (pix_src.size() > 0) && !px_hold;
      pix_data_r  = (pix_src.size() > 0) ? pix_src[0] : 16'd0;
      px_take     = pix_valid_r && pix_ready;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk_50MHz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_bytes(input string name);
    int bad_idx;
    bad_idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad_idx < 0 && (i >= byte_log.size() || byte_log[i] !== exp_q[i])) bad_idx = i;
    end
    if (bad_idx < 0 && byte_log.size() != exp_q.size()) bad_idx = exp_q.size();
    tests_run++;
    if (bad_idx >= 0) begin
      tests_failed++;
      $display("FAIL %s bytes: first difference at index %0d, got %0h (of %0d bytes), expected %0h (of %0d bytes)",
               name, bad_idx, (bad_idx < byte_log.size()) ? byte_log[bad_idx] : 9'h1FF,
               byte_log.size(), (bad_idx < exp_q.size()) ? exp_q[bad_idx] : 9'h1FF, exp_q.size());
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    done_log.delete();
    err_log.delete();
    byte_log.delete();
    exp_q.delete();
    en_cnt = 0;
  endtask

  task automatic push_cmds(input logic [15:0] x0, input logic [15:0] x1,
                           input logic [15:0] y0, input logic [15:0] y1);
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, x0[15:8]});
    exp_q.push_back({1'b1, x0[7:0]});
    exp_q.push_back({1'b1, x1[15:8]});
    exp_q.push_back({1'b1, x1[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, y0[15:8]});
    exp_q.push_back({1'b1, y0[7:0]});
    exp_q.push_back({1'b1, y1[15:8]});
    exp_q.push_back({1'b1, y1[7:0]});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pixel(input logic [15:0] p);
    pix_src.push_back(p);
    exp_q.push_back({1'b1, p[15:8]});
    exp_q.push_back({1'b1, p[7:0]});
  endtask

  task automatic set_win(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1);
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
  endtask

  // Raise req, drop it once granted, then wait for the done/err pulse
  task automatic start_and_finish(input logic [1:0] r, input int budget);
    int n;
    req = r;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    req = 2'b00;
    n = 0;
    while (done_log.size() == 0 && err_log.size() == 0 && n < budget) begin tick(); n++; end
    repeat (3) tick();
  endtask

  function automatic logic [1:0] first2(input logic [1:0] q[$]);
    return (q.size() == 1) ? q[0] : 2'b11;
  endfunction

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [15:0] x0, x1, y0, y1;
    int          npix;
    logic [1:0]  exp_grant;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [8:0]  lit[19];
    logic [7:0]  gpack, dpack;
    logic [15:0] p;
    int          n, bad;
    bit          reached;

    // rr priority after the hand sequences below is client 1
    vecs[0] = '{"px1_tie",    2'b11, 16'd2,   16'd2,   16'd2,   16'd2,   1,   2'b10, 1'b0};
    vecs[1] = '{"x1_lt_x0",   2'b11, 16'd5,   16'd3,   16'd0,   16'd0,   0,   2'b01, 1'b1};
    vecs[2] = '{"x1_eq_hres", 2'b11, 16'd0,   16'd160, 16'd0,   16'd0,   0,   2'b10, 1'b1};
    vecs[3] = '{"corner",     2'b10, 16'd159, 16'd159, 16'd239, 16'd239, 1,   2'b10, 1'b0};
    vecs[4] = '{"y1_eq_vres", 2'b11, 16'd0,   16'd0,   16'd0,   16'd240, 0,   2'b01, 1'b1};
    vecs[5] = '{"y1_lt_y0",   2'b01, 16'd0,   16'd0,   16'd3,   16'd2,   0,   2'b01, 1'b1};
    vecs[6] = '{"rect3x2",    2'b11, 16'd10,  16'd12,  16'd20,  16'd21,  6,   2'b10, 1'b0};
    vecs[7] = '{"full_row",   2'b11, 16'd0,   16'd159, 16'd0,   16'd0,   160, 2'b01, 1'b0};

    lit = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101,
            9'h02C, 9'h1A5, 9'h1A5, 9'h112, 9'h134, 9'h1FF, 9'h1FF, 9'h100, 9'h100};

    sys_rst_n = 1'b0;
    init_data = 9'd0; init_en_write = 1'b0; init_done = 1'b0;
    req = 2'b00;
    set_win(16'd0, 16'd0, 16'd0, 16'd0);
    #35;
    chk("reset outputs", {lcd_data, lcd_en_write, init_wr_done, grant, pix_ready, draw_done, draw_err}, 32'd0);
    tick();
    sys_rst_n = 1'b1;

    // INIT passthrough, draw request held off
    clear_logs();
    init_en_write = 1'b1; init_data = 9'h011; req = 2'b01;
    tick();
    chk("init lcd_data", lcd_data, 9'h011);
    chk("init en_write", lcd_en_write, 1'b1);
    wr_man = 1'b1;
    #2;
    chk("init wr_done high", init_wr_done, 1'b1);
    tick();
    wr_man = 1'b0;
    #1;
    chk("init wr_done low", init_wr_done, 1'b0);
    repeat (5) tick();
    chk("no grant in init", grant_log.size(), 0);
    req = 2'b00;

    init_done = 1'b1;
    repeat (2) tick();
    wr_man = 1'b1;
    #1;
    chk("init gated after done", {init_wr_done, lcd_en_write}, 2'b00);
    wr_man = 1'b0; init_en_write = 1'b0; init_data = 9'd0;
    auto_wr = 1'b1;
    tick();

    // req=11 held through four transactions
    clear_logs();
    set_win(16'd0, 16'd0, 16'd0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      push_cmds(16'd0, 16'd0, 16'd0, 16'd0);
      push_pixel(16'(k * 16'h1111));
    end
    req = 2'b11;
    n = 0;
    while (grant_log.size() < 4 && n < 1000) begin tick(); n++; end
    req = 2'b00;
    while (done_log.size() < 4 && n < 2000) begin tick(); n++; end
    repeat (3) tick();
    gpack = (grant_log.size() == 4) ? {grant_log[0], grant_log[1], grant_log[2], grant_log[3]} : 8'h00;
    dpack = (done_log.size() == 4) ? {done_log[0], done_log[1], done_log[2], done_log[3]} : 8'h00;
    chk("rr grants", gpack, 8'b01_10_01_10);
    chk("rr dones", dpack, 8'b01_10_01_10);
    cmp_bytes("rr");

    // 2x2 window with fixed pixel list, checked against a literal byte list
    clear_logs();
    set_win(16'd0, 16'd1, 16'd0, 16'd1);
    pix_src.push_back(16'hA5A5); pix_src.push_back(16'h1234);
    pix_src.push_back(16'hFFFF); pix_src.push_back(16'h0000);
    for (int i = 0; i < 19; i++) exp_q.push_back(lit[i]);
    start_and_finish(2'b01, 500);
    chk("2x2 grant", first2(grant_log), 2'b01);
    chk("2x2 draw_done", first2(done_log), 2'b01);
    chk("2x2 no err", err_log.size(), 0);
    cmp_bytes("2x2");

    // vector table
    foreach (vecs[i]) begin
      clear_logs();
      set_win(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      if (!vecs[i].exp_err) begin
        push_cmds(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
        for (int k = 0; k < vecs[i].npix; k++) begin
          p = 16'(16'hC3A0 + k * 16'h0111);
          push_pixel(p);
        end
      end
      start_and_finish(vecs[i].req, 4000);
      chk({vecs[i].name, " grant"}, first2(grant_log), vecs[i].exp_grant);
      if (vecs[i].exp_err) begin
        chk({vecs[i].name, " draw_err"}, first2(err_log), vecs[i].exp_grant);
        chk({vecs[i].name, " no done"}, done_log.size(), 0);
        chk({vecs[i].name, " no lcd traffic"}, en_cnt, 0);
      end else begin
        chk({vecs[i].name, " draw_done"}, first2(done_log), vecs[i].exp_grant);
        chk({vecs[i].name, " no err"}, err_log.size(), 0);
        cmp_bytes(vecs[i].name);
      end
    end

    // 10-cycle pixel stall in FETCH, then resume
    clear_logs();
    set_win(16'd1, 16'd1, 16'd1, 16'd1);
    push_cmds(16'd1, 16'd1, 16'd1, 16'd1);
    push_pixel(16'hBEEF);
    px_hold = 1'b1;
    req = 2'b10;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    req = 2'b00;
    n = 0;
    while (!pix_ready && n < 200) begin tick(); n++; end
    chk("stall fetch reached", pix_ready, 1'b1);
    bad = 0;
    repeat (10) begin
      tick();
      if (lcd_en_write || !pix_ready) bad++;
    end
    chk("stall en_write low", bad, 0);
    px_hold = 1'b0;
    n = 0;
    while (done_log.size() == 0 && err_log.size() == 0 && n < 200) begin tick(); n++; end
    repeat (3) tick();
    chk("stall draw_done", first2(done_log), 2'b10);
    chk("stall no err", err_log.size(), 0);
    cmp_bytes("stall");

`ifdef LCD_ARB_TIMEOUT_EN
    // 20-cycle stall exceeds the 16-cycle watchdog
    clear_logs();
    set_win(16'd4, 16'd4, 16'd4, 16'd4);
    pix_src.push_back(16'h7E57);
    px_hold = 1'b1;
    req = 2'b01;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    req = 2'b00;
    n = 0;
    while (!pix_ready && n < 200) begin tick(); n++; end
    repeat (20) tick();
    chk("timeout draw_err", first2(err_log), 2'b01);
    chk("timeout no done", done_log.size(), 0);
    chk("timeout back to arb", {pix_ready, lcd_en_write}, 2'b00);
    pix_src.delete();
    px_hold = 1'b0;
    repeat (2) tick();
`endif

    // async reset while a pixel high byte is pending
    clear_logs();
    set_win(16'd3, 16'd3, 16'd3, 16'd3);
    pix_src.push_back(16'h5AC3);
    req = 2'b01;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    req = 2'b00;
    n = 0;
    while (!(byte_log.size() == 11 && lcd_en_write) && n < 300) begin tick(); n++; end
    reached = (byte_log.size() == 11) && lcd_en_write && (lcd_data == 9'h15A);
    chk("phi reached", reached, 1'b1);
    auto_wr = 1'b0;
    init_done = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("reset mid-phi outputs", {lcd_data, lcd_en_write, init_wr_done, grant, pix_ready, draw_done, draw_err}, 32'd0);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (4) tick();
    chk("no done after reset", done_log.size(), 0);
    chk("no err after reset", err_log.size(), 0);
    pix_src.delete();
    init_en_write = 1'b1; init_data = 9'h0AB;
    #1;
    chk("init after reset", {lcd_en_write, lcd_data}, {1'b1, 9'h0AB});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
